// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// The optional IFETCH_NOP_SQUASH_EN build squashes all-zero fetched words.
package ifetch_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam int unsigned DEF_ADDR_W       = 32;
    localparam int unsigned DEF_DATA_W       = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'd100;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } ifetch_state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr;
    } ifetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries; flush wins over push and pop.
// Push while full is accepted only when a pop happens in the same cycle.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = ifetch_entry_t,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  entry_t           entry_i,
    input  logic             pop_i,
    output entry_t           head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push_ok;
    logic               pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // NOTE: storage is deliberately not reset; the head is masked while empty,
    // so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (rst_n && !flush_i && push_ok) mem_q[wr_ptr_q] <= entry_i;
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, buffers words, handles redirects.
// Define IFETCH_NOP_SQUASH_EN to drop all-zero fetched words (PC still advances).
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fetch_busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    ifetch_state_t     state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    entry_t            fifo_head, fifo_in;
    logic              pop, fetch_ok, push;
    logic              lint_unused;

    assign pop        = inst_valid & inst_ready;
    assign fetch_ok   = (state_q == FETCH) & ~redirect_valid & (~fifo_full | pop);
`ifdef IFETCH_NOP_SQUASH_EN
    assign push       = fetch_ok & (imem_data != '0);
`else
    assign push       = fetch_ok;
`endif
    assign fifo_in    = '{pc: fetch_pc_q, instr: imem_data};
    assign lint_unused = ^{fifo_count, redirect_pc[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            IDLE:    if (run)  state_d = FETCH;
            FETCH:   if (!run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Redirect overrides both hold and sequential advance; low bits are forced to word alignment.
        if (redirect_valid)
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
        else if (fetch_ok)
            fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
    end

    ifetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (push),
        .entry_i (fifo_in),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign inst_valid = ~fifo_empty;
    assign inst_data  = fifo_head.instr;
    assign inst_pc    = fifo_head.pc;
    assign imem_addr  = fetch_pc_q;
    assign fetch_busy = (state_q == FETCH);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: queue-based reference model plus directed literal pins.
// Honours IFETCH_NOP_SQUASH_EN when the design is built with it.
module tb_ifetch_ctrl;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'd100;
`ifdef IFETCH_NOP_SQUASH_EN
    localparam bit SQUASH = 1'b1;
`else
    localparam bit SQUASH = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              run = 1'b0;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              fetch_busy;

    always #5 clk = ~clk;

    ifetch_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fetch_busy     (fetch_busy)
    );

    // Program image: known words at 100..112, zero fillers at 104/108 and every address with [5:2]==0xB.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd100: return 32'h0022_1820;
            32'd104: return 32'h0000_0000;
            32'd108: return 32'h0000_0000;
            32'd112: return 32'h0123_2022;
            default: begin
                if (a[5:2] == 4'hB) return 32'h0;
                return {a[15:0], ~a[15:0]} | 32'h1;
            end
        endcase
    endfunction

    assign imem_data = mem_word(imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    bit          m_busy;
    bit          m_known = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        bit          e_valid;
        logic [31:0] e_pc, e_data;
        e_valid = (m_q.size() != 0);
        e_pc    = e_valid ? m_q[0].pc    : 32'h0;
        e_data  = e_valid ? m_q[0].instr : 32'h0;
        check("inst_valid", 32'(inst_valid), 32'(e_valid));
        check("inst_pc",    inst_pc,         e_pc);
        check("inst_data",  inst_data,       e_data);
        check("imem_addr",  imem_addr,       m_pc);
        check("fetch_busy", 32'(fetch_busy), 32'(m_busy));
    endtask

    // Drive inputs after the falling edge, then compare once they have settled.
    task automatic drive(input bit rst, input bit r, input bit rdy, input bit rv, input logic [31:0] rpc);
        @(negedge clk);
        rst_n          = rst;
        run            = r;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        if (m_known) compare_model();
    endtask

    // Advance the reference model across the rising edge.
    task automatic tick();
        bit          pop;
        logic [31:0] w;
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_pc    = RESET_PC;
            m_busy  = 1'b0;
            m_known = 1'b1;
        end else begin
            pop = (m_q.size() != 0) && inst_ready;
            if (redirect_valid) begin
                m_q.delete();
                m_pc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (m_busy && m_q.size() < DEPTH) begin
                    w = mem_word(m_pc);
                    if (!(SQUASH && w == 32'h0)) m_q.push_back('{pc: m_pc, instr: w});
                    m_pc = m_pc + 32'd4;
                end
            end
            m_busy = run;
        end
    endtask

    task automatic cyc(input bit rst, input bit r, input bit rdy, input bit rv, input logic [31:0] rpc);
        drive(rst, r, rdy, rv, rpc);
        tick();
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        // Straight-line fetch with decode always ready.
        do_reset();
        drive(1, 1, 1, 0, 0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_addr",  imem_addr,       32'd100);
        check("rst_busy",  32'(fetch_busy), 32'd0);
        check("rst_pc",    inst_pc,         32'd0);
        check("rst_data",  inst_data,       32'd0);
        tick();
        drive(1, 1, 1, 0, 0);
        check("f0_busy", 32'(fetch_busy), 32'd1);
        check("f0_addr", imem_addr,       32'd100);
        tick();
        drive(1, 1, 1, 0, 0);
        check("f1_pc",   inst_pc,   32'd100);
        check("f1_data", inst_data, 32'h0022_1820);
        tick();
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        drive(1, 1, 1, 0, 0);
        check("f4_pc",   inst_pc,   32'd112);
        check("f4_data", inst_data, 32'h0123_2022);
        tick();

        // Backpressure from the start, then release.
        do_reset();
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
`ifndef IFETCH_NOP_SQUASH_EN
        check("bp_addr",  imem_addr,       32'd108);
        check("bp_valid", 32'(inst_valid), 32'd1);
        check("bp_pc",    inst_pc,         32'd100);
`endif
        tick();
        for (int i = 0; i < 6; i++) cyc(1, 1, 1, 0, 0);

        // Redirect to a misaligned target while the buffer is full.
        do_reset();
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 32'h71);
        drive(1, 1, 1, 0, 0);
        check("rd_valid", 32'(inst_valid), 32'd0);
        check("rd_addr",  imem_addr,       32'd112);
        tick();
        drive(1, 1, 1, 0, 0);
        check("rd_pc",   inst_pc,   32'd112);
        check("rd_data", inst_data, 32'h0123_2022);
        tick();

        // Redirect while stopped loads the PC without fetching.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 32'd200);
        drive(1, 0, 0, 0, 0);
        check("idle_rd_addr",  imem_addr,       32'd200);
        check("idle_rd_busy",  32'(fetch_busy), 32'd0);
        check("idle_rd_valid", 32'(inst_valid), 32'd0);
        tick();
        drive(1, 0, 1, 0, 0);
        check("idle_hold_addr", imem_addr, 32'd200);
        tick();

        // Reset mid-stream with entries buffered.
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0);
        check("mid_rst_valid", 32'(inst_valid), 32'd0);
        check("mid_rst_addr",  imem_addr,       32'd100);
        check("mid_rst_busy",  32'(fetch_busy), 32'd0);
        tick();

        // PC wraps modulo 2^32.
        cyc(1, 1, 1, 1, 32'hFFFF_FFF8);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        drive(1, 1, 1, 0, 0);
        check("wrap_addr", imem_addr, 32'h0);
        tick();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit          r_rst, r_run, r_rdy, r_rv;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 199) != 0);
            r_run = ($urandom_range(0, 7) != 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_rv  = ($urandom_range(0, 15) == 0);
            r_pc  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            cyc(r_rst, r_run, r_rdy, r_rv, r_pc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction-fetch controller that sequences the byte-addressed, big-endian, combinational-read instruction memory for the pipelined CPU. It owns the fetch PC and drives the memory address each cycle. It buffers fetched words in a small prefetch FIFO and presents them to decode over a valid/ready handshake. It also applies branch/jump redirects by flushing the buffer and reloading the PC.

Parameters:
RESET_PC, 32'd100, fetch address loaded on reset (first program word)
FIFO_DEPTH, 2, prefetch entries (power of two, >=2)
ADDR_W, 32, PC / memory address width
DATA_W, 32, instruction width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, synchronous, active-low
run  in  1  fetch enable from core control
imem_addr  out  ADDR_W  address to instruction memory (= fetch_pc)
imem_data  in  DATA_W  word returned combinationally for imem_addr in the same cycle
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  ADDR_W  redirect target
inst_valid  out  1  FIFO head valid
inst_ready  in  1  decode accepts head
inst_data  out  DATA_W  head instruction (0 when empty)
inst_pc  out  ADDR_W  head PC (0 when empty)
fetch_busy  out  1  state == FETCH

Behaviour:
- Reset (rst_n=0 at a clk edge): fetch_pc=RESET_PC, FIFO cleared, state=IDLE. Outputs read inst_valid=0, inst_data=0, inst_pc=0, fetch_busy=0, imem_addr=RESET_PC. Reset mid-operation discards all buffered entries and any pending redirect.
- FSM: IDLE -> FETCH when run=1; FETCH -> IDLE when run=0. In IDLE no pushes occur; the FIFO keeps its contents and still drains to decode.
- pop = inst_valid & inst_ready.
- push = FETCH & !redirect_valid & (count<FIFO_DEPTH | pop). A simultaneous pop and push on a full FIFO is allowed, giving one word per cycle throughput.
- On push, {fetch_pc, imem_data} is written at the edge and fetch_pc += 4. Latency is 1 cycle: the word addressed in cycle N appears at the head in cycle N+1 if the FIFO was empty.
- Redirect has top priority, independent of state and run. At the edge the FIFO is flushed (including the head, even if popped that cycle), the current imem_data is not pushed, and fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}. Misaligned targets are silently aligned. The next cycle shows inst_valid=0 and imem_addr at the new PC.
- PC arithmetic is modulo 2^ADDR_W: 0xFFFFFFFC + 4 wraps to 0. Address decode and range checking belong to the memory, not this block.
- Count width is clog2(FIFO_DEPTH)+1. Full means count==FIFO_DEPTH; empty means count==0. Read/write pointers wrap modulo FIFO_DEPTH.
- inst_valid, inst_data and inst_pc are registered FIFO-head outputs, with no combinational path from imem_data.

Optional Feature:
IFETCH_NOP_SQUASH_EN
- Defined: a fetched word equal to 32'h0000_0000 (pipeline stall filler) is not pushed, but fetch_pc still advances by 4. Decode never sees all-zero words.
- Undefined: all-zero words are pushed like any other instruction.

Decomposition:
- Package ifetch_pkg holds:
  - typedef enum {IDLE, FETCH} ifetch_state_t
  - struct ifetch_entry_t {pc, instr}
  - localparam INSTR_BYTES=4
  - default RESET_PC constant
- Sub-module ifetch_fifo: synchronous FIFO of ifetch_entry_t with push, pop, flush, full, empty and count. Flush has priority over push and pop.

Test Plan:
- Reset release, run=1, inst_ready=1: imem_addr=100 in cycle 0. Cycle 1 gives inst_valid=1, inst_pc=100, inst_data=32'h00221820, then pc 104, 108, 112 (32'h01232022) on consecutive cycles.
- Backpressure, inst_ready=0 from start: FIFO holds pc 100 and 104, imem_addr stalls at 108, inst_valid stays 1 with pc 100. Raising inst_ready delivers 100, 104, 108 with no gap or duplicate.
- Redirect to 112 while FIFO is full and inst_ready=1: next cycle inst_valid=0 and imem_addr=112. The following cycle gives inst_pc=112, inst_data=32'h01232022. Entries 100 and 104 are never delivered.
- redirect_pc=32'h71 -> fetch resumes at 0x70 (112). Redirect while run=0 also loads the PC without pushing.
- rst_n=0 for one edge mid-stream with 2 entries buffered: next cycle inst_valid=0, imem_addr=100, fetch_busy=0.
- With IFETCH_NOP_SQUASH_EN defined: delivered sequence is pc 100, 112, 116, 120, 124, with 104/108 (zero words) absent. Without the macro, 104 and 108 appear with inst_data=0.
